wam_hole_ctl: RTL and testbench

- Per-hole mole lifecycle controller. It is the consumer/responder to the mole generator.
- The generator issues one-cycle spawn requests. This block raises the mole, times its exposure, and judges switch taps against it.
- It returns hit/miss events to the score counter and busy status back to the generator.
- Sits between the generator, the tap edge-detector, and the score/LED logic.

---
 rtl/wam_hole_ctl_pkg.sv | 26 ++
 rtl/wam_hole_fsm.sv | 118 +++++++++++
 rtl/wam_hole_ctl.sv | 80 ++++++++
 tb/tb_wam_hole_ctl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wam_hole_ctl_pkg.sv
// Shared definitions for the whack-a-mole hole controller.
//   hole_state_e : per-hole lifecycle state (2-bit encoding)
//   DEF_*        : default geometry and tick timings
//   sat_miss     : clamps a one-bit-wider miss total to the counter range
package wam_hole_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UP    = 2'd1,
    ST_FLASH = 2'd2,
    ST_COOL  = 2'd3
  } hole_state_e;

  localparam int DEF_N_HOLES     = 8;
  localparam int DEF_CNT_W       = 4;
  localparam int DEF_UP_TICKS    = 12;
  localparam int DEF_FLASH_TICKS = 3;
  localparam int DEF_COOL_TICKS  = 4;
  localparam int MISS_CNT_W      = 8;

  // The carry bit of the widened sum marks overflow; pin to all-ones instead of wrapping.
  function automatic logic [MISS_CNT_W-1:0] sat_miss(input logic [MISS_CNT_W:0] sum);
    return sum[MISS_CNT_W] ? {MISS_CNT_W{1'b1}} : sum[MISS_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/wam_hole_fsm.sv
// One hole's mole lifecycle: IDLE -> UP -> (FLASH on hit) -> COOL -> IDLE.
// Ports:
//   clk, clr      : clock, synchronous active-low reset
//   tick          : game-tick strobe (may be held high)
//   spawn, tap    : one-cycle requests for this hole
//   holes/flash   : state decodes UP / FLASH
//   busy          : hole not IDLE
//   hit, miss     : registered one-cycle event pulses
//   miss_evt      : the miss pulse one cycle early, for the shared miss counter
module wam_hole_fsm
  import wam_hole_ctl_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int UP_TICKS    = DEF_UP_TICKS,
  parameter int FLASH_TICKS = DEF_FLASH_TICKS,
  parameter int COOL_TICKS  = DEF_COOL_TICKS
) (
  input  logic clk,
  input  logic clr,
  input  logic tick,
  input  logic spawn,
  input  logic tap,
  output logic holes,
  output logic flash,
  output logic busy,
  output logic hit,
  output logic miss,
  output logic miss_evt
);

  hole_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;
  logic             miss_q, miss_d;

  logic last_tick;
  assign last_tick = (cnt_q == CNT_W'(1));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A tap arriving with the spawn is deliberately dropped: no mole is up yet.
        if (spawn) begin
          state_d = ST_UP;
          cnt_d   = CNT_W'(UP_TICKS);
        end
      end
      ST_UP: begin
        // Tap is tested before tick so a tap on the final tick scores a hit, not a miss.
        if (tap) begin
          state_d = ST_FLASH;
          cnt_d   = CNT_W'(FLASH_TICKS);
          hit_d   = 1'b1;
        end else if (tick) begin
          if (last_tick) begin
            state_d = ST_COOL;
            cnt_d   = CNT_W'(COOL_TICKS);
            miss_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_FLASH: begin
        if (tick) begin
          if (last_tick) begin
            state_d = ST_COOL;
            cnt_d   = CNT_W'(COOL_TICKS);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_COOL: begin
        if (tick) begin
          if (last_tick) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    if (!clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign holes    = (state_q == ST_UP);
  assign flash    = (state_q == ST_FLASH);
  assign busy     = (state_q != ST_IDLE);
  assign hit      = hit_q;
  assign miss     = miss_q;
  assign miss_evt = miss_d;

endmodule

// File: rtl/wam_hole_ctl.sv
// Whack-a-mole hole array: N_HOLES independent lifecycle FSMs plus a
// saturating count of missed moles.
// Ports:
//   clk, clr          : clock, synchronous active-low reset
//   tick              : game-tick strobe
//   spawn[N], tap[N]  : one-cycle per-hole requests / debounced taps
//   holes[N]          : mole visible
//   flash[N]          : hit mole flashing
//   busy[N]           : hole unavailable to the generator
//   hit[N], miss[N]   : one-cycle event pulses
//   miss_cnt[8]       : misses since reset, saturating at 255
module wam_hole_ctl
  import wam_hole_ctl_pkg::*;
#(
  parameter int N_HOLES     = DEF_N_HOLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int UP_TICKS    = DEF_UP_TICKS,
  parameter int FLASH_TICKS = DEF_FLASH_TICKS,
  parameter int COOL_TICKS  = DEF_COOL_TICKS
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  tick,
  input  logic [N_HOLES-1:0]    spawn,
  input  logic [N_HOLES-1:0]    tap,
  output logic [N_HOLES-1:0]    holes,
  output logic [N_HOLES-1:0]    flash,
  output logic [N_HOLES-1:0]    busy,
  output logic [N_HOLES-1:0]    hit,
  output logic [N_HOLES-1:0]    miss,
  output logic [MISS_CNT_W-1:0] miss_cnt
);

  localparam int PC_W = $clog2(N_HOLES + 1);

  logic [N_HOLES-1:0]    miss_evt;
  logic [PC_W-1:0]       miss_pop;
  logic [MISS_CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  for (genvar i = 0; i < N_HOLES; i++) begin : g_hole
    wam_hole_fsm #(
      .CNT_W      (CNT_W),
      .UP_TICKS   (UP_TICKS),
      .FLASH_TICKS(FLASH_TICKS),
      .COOL_TICKS (COOL_TICKS)
    ) u_fsm (
      .clk     (clk),
      .clr     (clr),
      .tick    (tick),
      .spawn   (spawn[i]),
      .tap     (tap[i]),
      .holes   (holes[i]),
      .flash   (flash[i]),
      .busy    (busy[i]),
      .hit     (hit[i]),
      .miss    (miss[i]),
      .miss_evt(miss_evt[i])
    );
  end

  // Counting the pre-register miss events keeps miss_cnt in step with the miss pulses.
  always_comb begin
    miss_pop = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      miss_pop = miss_pop + PC_W'(miss_evt[i]);
    end
    miss_cnt_d = sat_miss({1'b0, miss_cnt_q} + (MISS_CNT_W + 1)'(miss_pop));
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      miss_cnt_q <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_wam_hole_ctl.sv
// Self-checking bench for wam_hole_ctl: directed scenarios against hand-derived
// values, then randomized traffic against a tick-budget reference model.
module tb_wam_hole_ctl;

  localparam int N     = 8;
  localparam int UP    = 12;
  localparam int FLASH = 3;
  localparam int COOL  = 4;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         tick = 1'b0;
  logic [N-1:0] spawn = '0;
  logic [N-1:0] tap = '0;
  logic [N-1:0] holes, flash, busy, hit, miss;
  logic [7:0]   miss_cnt;

  int total = 0;
  int bad   = 0;

  wam_hole_ctl #(
    .N_HOLES    (N),
    .CNT_W      (4),
    .UP_TICKS   (UP),
    .FLASH_TICKS(FLASH),
    .COOL_TICKS (COOL)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .tick    (tick),
    .spawn   (spawn),
    .tap     (tap),
    .holes   (holes),
    .flash   (flash),
    .busy    (busy),
    .hit     (hit),
    .miss    (miss),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: each hole is described by two tick budgets.
  //   up_left   : ticks until the mole expires (nonzero means the mole is visible)
  //   post_left : ticks until the hole is free again; above COOL it is still flashing
  int           up_left[N];
  int           post_left[N];
  logic [N-1:0] m_hit  = '0;
  logic [N-1:0] m_miss = '0;
  int           m_cnt  = 0;

  initial begin
    for (int i = 0; i < N; i++) begin
      up_left[i]   = 0;
      post_left[i] = 0;
    end
  end

  task automatic model_update();
    int nm;
    nm     = 0;
    m_hit  = '0;
    m_miss = '0;
    if (!clr) begin
      for (int i = 0; i < N; i++) begin
        up_left[i]   = 0;
        post_left[i] = 0;
      end
      m_cnt = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (up_left[i] > 0) begin
        if (tap[i]) begin
          up_left[i]   = 0;
          post_left[i] = FLASH + COOL;
          m_hit[i]     = 1'b1;
        end else if (tick) begin
          up_left[i]--;
          if (up_left[i] == 0) begin
            post_left[i] = COOL;
            m_miss[i]    = 1'b1;
            nm++;
          end
        end
      end else if (post_left[i] > 0) begin
        if (tick) post_left[i]--;
      end else if (spawn[i]) begin
        up_left[i] = UP;
      end
    end
    m_cnt = (m_cnt + nm > 255) ? 255 : m_cnt + nm;
  endtask

  function automatic logic [47:0] model_vec();
    logic [N-1:0] h, f, b;
    for (int i = 0; i < N; i++) begin
      h[i] = (up_left[i] > 0);
      f[i] = (up_left[i] == 0) && (post_left[i] > COOL);
      b[i] = (up_left[i] > 0) || (post_left[i] > 0);
    end
    return {h, f, b, m_hit, m_miss, 8'(m_cnt)};
  endfunction

  function automatic logic [47:0] obs();
    return {holes, flash, busy, hit, miss, miss_cnt};
  endfunction

  function automatic logic [47:0] pack(input logic [7:0] h, input logic [7:0] f,
                                       input logic [7:0] b, input logic [7:0] hi,
                                       input logic [7:0] m, input logic [7:0] c);
    return {h, f, b, hi, m, c};
  endfunction

  // Apply inputs for one cycle, advance the model at the edge, sample 1 ns later.
  task automatic step(input logic t, input logic [N-1:0] sp, input logic [N-1:0] tp);
    tick  = t;
    spawn = sp;
    tap   = tp;
    @(posedge clk);
    model_update();
    #1;
    tick  = 1'b0;
    spawn = '0;
    tap   = '0;
  endtask

  task automatic test_reset();
    logic [47:0] want;
    clr = 1'b0;
    step(0, '0, '0);
    step(0, '0, '0);
    want = pack(0, 0, 0, 0, 0, 0);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL reset_initial got=%h want=%h", obs(), want); end
    clr = 1'b1;
    step(0, 8'h08, '0);
    step(1, '0, '0);
    want = pack(8'h08, 0, 8'h08, 0, 0, 0);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL reset_pre_up got=%h want=%h", obs(), want); end
    clr = 1'b0;
    step(1, '0, 8'h08);
    step(0, '0, '0);
    want = pack(0, 0, 0, 0, 0, 0);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL reset_mid_game got=%h want=%h", obs(), want); end
    clr = 1'b1;
  endtask

  task automatic test_hit();
    logic [47:0] want;
    step(0, 8'h04, '0);
    want = pack(8'h04, 0, 8'h04, 0, 0, 0);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL hit_spawn got=%h want=%h", obs(), want); end
    repeat (5) step(1, '0, '0);
    step(0, '0, 8'h04);
    want = pack(0, 8'h04, 8'h04, 8'h04, 0, 0);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL hit_pulse got=%h want=%h", obs(), want); end
    step(0, '0, '0);
    want = pack(0, 8'h04, 8'h04, 0, 0, 0);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL hit_one_cycle got=%h want=%h", obs(), want); end
    repeat (2) step(1, '0, '0);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL hit_flash_hold got=%h want=%h", obs(), want); end
    step(1, '0, '0);
    want = pack(0, 0, 8'h04, 0, 0, 0);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL hit_to_cool got=%h want=%h", obs(), want); end
    repeat (3) step(1, '0, '0);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL hit_cool_hold got=%h want=%h", obs(), want); end
    step(1, '0, '0);
    want = pack(0, 0, 0, 0, 0, 0);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL hit_idle got=%h want=%h", obs(), want); end
  endtask

  task automatic test_miss();
    logic [47:0] want;
    step(0, 8'h01, '0);
    repeat (11) step(1, '0, '0);
    want = pack(8'h01, 0, 8'h01, 0, 0, 0);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL miss_still_up got=%h want=%h", obs(), want); end
    step(1, '0, '0);
    want = pack(0, 0, 8'h01, 0, 8'h01, 8'd1);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL miss_pulse got=%h want=%h", obs(), want); end
    step(0, '0, '0);
    want = pack(0, 0, 8'h01, 0, 0, 8'd1);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL miss_one_cycle got=%h want=%h", obs(), want); end
    repeat (3) step(1, '0, '0);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL miss_cool got=%h want=%h", obs(), want); end
    step(1, '0, '0);
    want = pack(0, 0, 0, 0, 0, 8'd1);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL miss_idle got=%h want=%h", obs(), want); end
  endtask

  task automatic test_race();
    logic [47:0] want;
    step(0, 8'h20, '0);
    repeat (11) step(1, '0, '0);
    step(1, '0, 8'h20);
    want = pack(0, 8'h20, 8'h20, 8'h20, 0, 8'd1);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL race_tap_wins got=%h want=%h", obs(), want); end
    repeat (FLASH + COOL) step(1, '0, '0);
    want = pack(0, 0, 0, 0, 0, 8'd1);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL race_drain got=%h want=%h", obs(), want); end
  endtask

  task automatic test_ignored();
    logic [47:0] want;
    step(0, '0, 8'h02);
    want = pack(0, 0, 0, 0, 0, 8'd1);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL ign_tap_idle got=%h want=%h", obs(), want); end
    step(0, 8'h02, 8'h02);
    want = pack(8'h02, 0, 8'h02, 0, 0, 8'd1);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL ign_spawn_tap got=%h want=%h", obs(), want); end
    // A second spawn while up must not reload the exposure timer.
    repeat (5) step(1, '0, '0);
    step(0, 8'h02, '0);
    repeat (6) step(1, '0, '0);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL ign_spawn_up got=%h want=%h", obs(), want); end
    step(1, '0, '0);
    want = pack(0, 0, 8'h02, 0, 8'h02, 8'd2);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL ign_timer_kept got=%h want=%h", obs(), want); end
    step(0, '0, 8'h02);
    step(0, 8'h02, '0);
    want = pack(0, 0, 8'h02, 0, 0, 8'd2);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL ign_cool got=%h want=%h", obs(), want); end
    repeat (COOL) step(1, '0, '0);
    step(0, 8'h02, '0);
    step(0, '0, 8'h02);
    step(0, '0, 8'h02);
    want = pack(0, 8'h02, 8'h02, 0, 0, 8'd2);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL ign_tap_flash got=%h want=%h", obs(), want); end
    step(1, 8'h02, 8'h02);
    repeat (2) step(1, '0, '0);
    want = pack(0, 0, 8'h02, 0, 0, 8'd2);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL ign_flash_len got=%h want=%h", obs(), want); end
    repeat (COOL) step(1, '0, '0);
    want = pack(0, 0, 0, 0, 0, 8'd2);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL ign_idle got=%h want=%h", obs(), want); end
  endtask

  task automatic test_saturate();
    logic [47:0] want;
    int          exp_c;
    clr = 1'b0;
    step(0, '0, '0);
    clr   = 1'b1;
    exp_c = 0;
    for (int r = 0; r < 33; r++) begin
      step(1, 8'hFF, '0);
      repeat (UP - 1) step(1, '0, '0);
      step(1, '0, '0);
      exp_c = (exp_c + 8 > 255) ? 255 : exp_c + 8;
      want  = pack(0, 0, 8'hFF, 0, 8'hFF, 8'(exp_c));
      total++;
      if (obs() !== want) begin bad++; $display("FAIL sat_round%0d got=%h want=%h", r, obs(), want); end
      repeat (COOL) step(1, '0, '0);
    end
    want = pack(0, 0, 0, 0, 0, 8'd255);
    total++;
    if (obs() !== want) begin bad++; $display("FAIL sat_final got=%h want=%h", obs(), want); end
  endtask

  task automatic test_random();
    logic         t;
    logic         held;
    logic [N-1:0] sp, tp;
    int           errs;
    errs = 0;
    clr  = 1'b0;
    step(0, '0, '0);
    clr  = 1'b1;
    held = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) held = ($urandom_range(0, 2) == 0);
      t   = held | ($urandom_range(0, 2) == 0);
      sp  = N'($urandom & $urandom & $urandom);
      tp  = N'($urandom & $urandom);
      clr = ($urandom_range(0, 399) != 0);
      step(t, sp, tp);
      clr = 1'b1;
      total++;
      if (obs() !== model_vec()) begin
        bad++;
        errs++;
        if (errs <= 10) $display("FAIL rand_cycle%0d got=%h want=%h", c, obs(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_race();
    test_ignored();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
